hyper_mvblck_dram2lsab: RTL

- Hyperfabric block mover for the DRAM-to-LSAB direction, the counterpart of the LSAB-to-DRAM mover.
- On an ISSUE command it reads COUNT_REQ consecutive 32-bit words from DRAM through the MCU bulk port, starting at a collective address.
- The read data crosses trans_core on its own; this block only times the writes of that data into one LSAB section FIFO.
- It honours per-section full flags and reports the number of words delivered.

---
 rtl/hyper_mvblck_dram2lsab_if.sv | 46 ++++
 rtl/hyper_mvblck_dram2lsab.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hyper_mvblck_dram2lsab_if.sv
// -----------------------------------------------------------------------------
// hyper_mvblck_dram2lsab_if
// Purpose : bundles the command, MCU bulk-read and LSAB-write signals of the
//           DRAM-to-LSAB block mover into one interface.
// Modports:
//   slave  - the mover itself (takes commands and full flags, drives the
//            MCU request and the LSAB write strobe)
//   master - the environment (issues commands, owns the full flags)
// Signals :
//   START_ADDRESS[11:0], COUNT_REQ[5:0], SECTION[1:0], ISSUE  command
//   COUNT_SENT[5:0], WORKING                                   status
//   MCU_COLL_ADDRESS[11:0], MCU_REQUEST_ACCESS                 DRAM read
//   LSAB_0_FULL..LSAB_3_FULL                                   section flags
//   LSAB_WRITE, LSAB_SECTION[1:0], LSAB_INT                    LSAB write
// -----------------------------------------------------------------------------
interface hyper_mvblck_dram2lsab_if;
   logic [11:0] START_ADDRESS;
   logic [5:0]  COUNT_REQ;
   logic [1:0]  SECTION;
   logic        ISSUE;
   logic [5:0]  COUNT_SENT;
   logic        WORKING;
   logic [11:0] MCU_COLL_ADDRESS;
   logic        MCU_REQUEST_ACCESS;
   logic        LSAB_0_FULL;
   logic        LSAB_1_FULL;
   logic        LSAB_2_FULL;
   logic        LSAB_3_FULL;
   logic        LSAB_WRITE;
   logic [1:0]  LSAB_SECTION;
   logic        LSAB_INT;

   modport slave (
      input  START_ADDRESS, COUNT_REQ, SECTION, ISSUE,
      input  LSAB_0_FULL, LSAB_1_FULL, LSAB_2_FULL, LSAB_3_FULL,
      output COUNT_SENT, WORKING, MCU_COLL_ADDRESS, MCU_REQUEST_ACCESS,
      output LSAB_WRITE, LSAB_SECTION, LSAB_INT
   );

   modport master (
      output START_ADDRESS, COUNT_REQ, SECTION, ISSUE,
      output LSAB_0_FULL, LSAB_1_FULL, LSAB_2_FULL, LSAB_3_FULL,
      input  COUNT_SENT, WORKING, MCU_COLL_ADDRESS, MCU_REQUEST_ACCESS,
      input  LSAB_WRITE, LSAB_SECTION, LSAB_INT
   );
endinterface

// File: rtl/hyper_mvblck_dram2lsab.sv
// -----------------------------------------------------------------------------
// hyper_mvblck_dram2lsab
// Purpose : DRAM-to-LSAB block mover. On ISSUE it requests COUNT_REQ
//           consecutive words from the MCU bulk port and, READ_LATENCY cycles
//           after each request, strobes the LSAB write of the selected
//           section FIFO. Issue stalls while the section's full flag is high;
//           requests already in flight always complete.
// Ports   : CLK  - sole clock, posedge
//           RST  - synchronous, active-high reset
//           bus  - hyper_mvblck_dram2lsab_if.slave (command/MCU/LSAB signals)
// Param   : READ_LATENCY (1..15) request-to-write delay in cycles
// Option  : MVBLCK_DRAM2LSAB_INT_EN - when defined, LSAB_INT marks the write
//           of the last word of each command; otherwise LSAB_INT is 0.
// -----------------------------------------------------------------------------
module hyper_mvblck_dram2lsab #(
   parameter int unsigned READ_LATENCY = 8
) (
   input  logic                        CLK,
   input  logic                        RST,
   hyper_mvblck_dram2lsab_if.slave     bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Every pipeline slot except the output one; DRAIN may leave once these
   // are empty because the output slot is written this very cycle.
   localparam logic [READ_LATENCY-1:0] TAIL_MASK = {READ_LATENCY{1'b1}} >> 1;

   state_t                  state_q, state_d;
   logic [11:0]             addr_q, addr_d;
   logic [5:0]              count_q, count_d;
   logic [5:0]              issued_q, issued_d;
   logic [1:0]              section_q, section_d;
   logic [5:0]              count_sent_q, count_sent_d;
   logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
   logic                    req_s;
   logic                    working_s;
   logic                    full_sel_s;
   logic                    accept_s;

   assign accept_s = (state_q == ST_IDLE) && bus.ISSUE;

   // Select the full flag of the latched destination section.
   always_comb begin
      full_sel_s = 1'b0;
      case (section_q)
         2'd0:    full_sel_s = bus.LSAB_0_FULL;
         2'd1:    full_sel_s = bus.LSAB_1_FULL;
         2'd2:    full_sel_s = bus.LSAB_2_FULL;
         2'd3:    full_sel_s = bus.LSAB_3_FULL;
         default: full_sel_s = 1'b1;
      endcase
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.ISSUE) begin
               state_d = (bus.COUNT_REQ == 6'd0) ? ST_DONE : ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (req_s && ((issued_q + 6'd1) == count_q)) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_DRAIN: begin
            if ((pipe_valid_q & TAIL_MASK) == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs. The full flag gates the request in the same cycle.
   always_comb begin
      req_s     = 1'b0;
      working_s = 1'b0;
      case (state_q)
         ST_IDLE:  working_s = 1'b0;
         ST_READ: begin
            working_s = 1'b1;
            req_s     = (issued_q != count_q) && !full_sel_s;
         end
         ST_DRAIN: working_s = 1'b1;
         ST_DONE:  working_s = 1'b1;
         default:  working_s = 1'b0;
      endcase
   end

   // Datapath next-state: command latch, address/issue counters, return pipe.
   always_comb begin
      addr_d       = addr_q;
      count_d      = count_q;
      issued_d     = issued_q;
      section_d    = section_q;
      count_sent_d = count_sent_q;
      pipe_valid_d = pipe_valid_q;
      pipe_valid_d[0] = req_s;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
         pipe_valid_d[i] = pipe_valid_q[i-1];
      end
      if (accept_s) begin
         addr_d       = bus.START_ADDRESS;
         count_d      = bus.COUNT_REQ;
         section_d    = bus.SECTION;
         issued_d     = 6'd0;
         count_sent_d = 6'd0;
      end else begin
         if (req_s) begin
            addr_d   = addr_q + 12'd1;   // 12-bit wrap is intended
            issued_d = issued_q + 6'd1;
         end else begin
            addr_d   = addr_q;
            issued_d = issued_q;
         end
         if (pipe_valid_q[READ_LATENCY-1]) begin
            count_sent_d = count_sent_q + 6'd1;
         end else begin
            count_sent_d = count_sent_q;
         end
      end
   end

   // Datapath registers; reset drops any returns still in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_q       <= 12'd0;
         count_q      <= 6'd0;
         issued_q     <= 6'd0;
         section_q    <= 2'd0;
         count_sent_q <= 6'd0;
         pipe_valid_q <= '0;
      end else begin
         addr_q       <= addr_d;
         count_q      <= count_d;
         issued_q     <= issued_d;
         section_q    <= section_d;
         count_sent_q <= count_sent_d;
         pipe_valid_q <= pipe_valid_d;
      end
   end

`ifdef MVBLCK_DRAM2LSAB_INT_EN
   logic [READ_LATENCY-1:0] pipe_last_q;
   logic                    last_s;

   // The request carrying the final word of the command.
   assign last_s = req_s && (issued_q == (count_q - 6'd1));

   // Last-word marker travels alongside the valid bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pipe_last_q <= '0;
      end else begin
         pipe_last_q[0] <= last_s;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_last_q[i] <= pipe_last_q[i-1];
         end
      end
   end

   assign bus.LSAB_INT = pipe_valid_q[READ_LATENCY-1] & pipe_last_q[READ_LATENCY-1];
`else
   assign bus.LSAB_INT = 1'b0;
`endif

   assign bus.MCU_REQUEST_ACCESS = req_s;
   assign bus.MCU_COLL_ADDRESS   = addr_q;
   assign bus.WORKING            = working_s;
   assign bus.COUNT_SENT         = count_sent_q;
   assign bus.LSAB_WRITE         = pipe_valid_q[READ_LATENCY-1];
   assign bus.LSAB_SECTION       = section_q;

endmodule
